hash_bram_packer: RTL and testbench
===================================

# hash_bram_packer

Upstream fill stage for the hash BRAM (BRAM_ID 0) read by the multiplication platform during AS_CALC and SA_CALC. It accepts the 32-bit output stream of the hash core through a valid/ready handshake and packs beat pairs into 64-bit words. It writes those words to consecutive BRAM addresses starting at a programmed base and raises `HASH_ready` once the requested number of words has landed.

## Interface
- `ADDR_STEP`, default 8: byte-address increment per 64-bit word written.
- `CNT_W`, default 16: width of the word-count input and internal counter.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `start`  input  1  one-cycle pulse that begins a fill; sampled only in IDLE or DONE.
- `base_addr`  input  32  first BRAM byte address; sampled on the accepted `start`.
- `word_count`  input  CNT_W  number of 64-bit words to write; sampled on the accepted `start`.
- `in_valid`  input  1  hash beat valid.
- `in_data`  input  32  hash beat payload.
- `in_ready`  output  1  beat accepted when `in_valid && in_ready`.
- `bram_waddr`  output  32  write address (registered).
- `bram_wdata`  output  64  write data (registered).
- `bram_wmask`  output  8  byte mask; 8'hFF whenever `bram_wen` is high, else 8'h00.
- `bram_wen`  output  1  write strobe, one cycle per word (registered).
- `HASH_ready`  output  1  level; high in DONE until the next accepted `start` or reset.

## Operation
- States: IDLE, FILL_LO, FILL_HI, DONE.
- IDLE/DONE + `start`:
  - latch `base_addr` into the address register and `word_count` into the remaining-word counter;
  - clear `HASH_ready`;
  - go to FILL_LO, or directly to DONE if `word_count == 0`.
- FILL_LO: `in_ready = 1`. On handshake, store `in_data` as bits [31:0] of the word and go to FILL_HI.
- FILL_HI: `in_ready = 1`. On handshake:
  - assemble `{in_data, lo}`;
  - register it onto `bram_wdata` and the current address onto `bram_waddr`;
  - pulse `bram_wen`;
  - advance the address by `ADDR_STEP` and decrement the counter;
  - go to FILL_LO if words remain, else to a one-cycle drain and then DONE.
- `in_ready` is 0 in IDLE, DONE and the drain cycle. Beats offered there are not consumed.
- Address arithmetic is 32-bit modulo 2^32 and wraps silently.
- Counter is CNT_W bits. The max value 2^CNT_W − 1 is legal.
- `start` in FILL_LO, FILL_HI or drain is ignored; the fill in progress continues unchanged.
- A dropped `in_valid` in any FILL state stalls the block indefinitely with no timeout. The half-word in FILL_HI is held.
- Reset mid-fill:
  - discards the partial word;
  - forces IDLE;
  - suppresses any pending `bram_wen` in the same cycle;
  - leaves already-written words in the BRAM untouched.

## Timing
- Reset values: `in_ready=0`, `bram_wen=0`, `bram_wmask=8'h00`, `bram_waddr=0`, `bram_wdata=0`, `HASH_ready=0`, state IDLE.
- Accepted `start` at cycle S: `in_ready` high from S+1.
- Full throughput: one beat per cycle, so one BRAM word every 2 cycles.
- High-half handshake at cycle H: `bram_wen`/`bram_waddr`/`bram_wdata` valid during cycle H+1 (one-cycle latency).
- Final high-half handshake at cycle H: write at H+1, `HASH_ready` high from H+2. The BRAM write has completed before the consumer can read.
- `word_count == 0`: `HASH_ready` high from S+1, no writes issued.

## Configuration
- `HASH_PACK_BSWAP_EN`
  - Defined: each 32-bit beat is byte-reversed before packing, e.g. `in_data` 32'h11223344 is stored as 32'h44332211. This gives little-endian hash lanes for big-endian cores.
  - Undefined: beats are stored unmodified.
- Timing and handshake are identical in both builds.

## Test plan
- Reset, then `start` with base 0x100, count 2, four back-to-back beats 0xA0..0xA3:
  - writes 64'h000000A1_000000A0 @0x100 and 64'h000000A3_000000A2 @0x108;
  - `HASH_ready` rises 2 cycles after the 4th beat.
- Same fill with `in_valid` toggled every other cycle: identical writes; `in_ready` never drops in FILL states; no beat lost or duplicated.
- `start` with count 0: `HASH_ready` high the next cycle; `bram_wen` never asserts.
- Base 0xFFFF_FFF8, count 2: second write lands at 0x0000_0000.
- Second `start` pulsed mid-fill (base 0x200, count 1): ignored; original 2-word fill completes at the original addresses.
- Reset asserted between the lo and hi beats of word 1 (count 3): no further writes; state IDLE; all outputs at reset values on the next cycle. Built with `HASH_PACK_BSWAP_EN`, a beat of 0x11223344 is written as 0x44332211.

Source files
------------

// File: rtl/hash_bram_packer.sv
// hash_bram_packer: packs pairs of 32-bit hash beats into 64-bit words and
// writes them to consecutive hash BRAM addresses, then raises HASH_ready.
//
// Optional build macro: HASH_PACK_BSWAP_EN (byte-reverse each beat before packing).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle fill request (honoured in IDLE/DONE only)
//   base_addr           first BRAM byte address, latched on accepted start
//   word_count          number of 64-bit words, latched on accepted start
//   in_valid/in_data    hash beat stream
//   in_ready            beat accepted when in_valid && in_ready
//   bram_waddr/wdata    registered write address/data
//   bram_wmask          8'hFF with bram_wen, else 8'h00
//   bram_wen            registered write strobe, one cycle per word
//   HASH_ready          level, high in DONE until next accepted start or reset
module hash_bram_packer #(
  parameter int unsigned ADDR_STEP = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      bram_waddr,
  output logic [63:0]      bram_wdata,
  output logic [7:0]       bram_wmask,
  output logic             bram_wen,
  output logic             HASH_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL_LO = 3'd1,
    FILL_HI = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           r_state;
  logic [31:0]      r_lo;
  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_wen;
  logic [31:0]      r_waddr;
  logic [63:0]      r_wdata;
  logic             r_hash_ready;

  state_t           w_state_nxt;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      w_addr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_in_ready_nxt;
  logic             w_wen_nxt;
  logic [31:0]      w_waddr_nxt;
  logic [63:0]      w_wdata_nxt;
  logic             w_hash_ready_nxt;
  logic             w_hs;
  logic [31:0]      w_beat;

  // in_ready is registered and tracks the FILL states exactly, so it is the handshake gate
  assign w_hs = in_valid && r_in_ready;

`ifdef HASH_PACK_BSWAP_EN
  // Little-endian lanes for big-endian cores
  assign w_beat = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign w_beat = in_data;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_wen_nxt   = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_addr_nxt  = base_addr;
          w_cnt_nxt   = word_count;
          w_state_nxt = (word_count == '0) ? DONE : FILL_LO;
        end
      end
      FILL_LO: begin
        if (w_hs) begin
          w_lo_nxt    = w_beat;
          w_state_nxt = FILL_HI;
        end
      end
      FILL_HI: begin
        if (w_hs) begin
          w_wdata_nxt = {w_beat, r_lo};
          w_waddr_nxt = r_addr;
          w_wen_nxt   = 1'b1;
          w_addr_nxt  = r_addr + 32'(ADDR_STEP);
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          // Drain cycle lets the last write land before HASH_ready rises
          w_state_nxt = (r_cnt == CNT_W'(1)) ? DRAIN : FILL_LO;
        end
      end
      DRAIN:   w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    w_in_ready_nxt   = (w_state_nxt == FILL_LO) || (w_state_nxt == FILL_HI);
    w_hash_ready_nxt = (w_state_nxt == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lo         <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b0;
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_hash_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lo         <= w_lo_nxt;
      r_addr       <= w_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_wen        <= w_wen_nxt;
      r_waddr      <= w_waddr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_hash_ready <= w_hash_ready_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign bram_wen   = r_wen;
  assign bram_wmask = {8{r_wen}};
  assign bram_waddr = r_waddr;
  assign bram_wdata = r_wdata;
  assign HASH_ready = r_hash_ready;

endmodule

// File: tb/tb_hash_bram_packer.sv
// tb_hash_bram_packer: directed self-checking bench for hash_bram_packer.
// Inputs change 1 time unit after the rising edge; outputs sampled there or on the falling edge.
module tb_hash_bram_packer;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [31:0]      bram_waddr;
  logic [63:0]      bram_wdata;
  logic [7:0]       bram_wmask;
  logic             bram_wen;
  logic             HASH_ready;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [31:0] q_addr[$];
  logic [63:0] q_data[$];

  hash_bram_packer #(.ADDR_STEP(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .bram_waddr (bram_waddr),
    .bram_wdata (bram_wdata),
    .bram_wmask (bram_wmask),
    .bram_wen   (bram_wen),
    .HASH_ready (HASH_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_beat(input logic [31:0] d);
`ifdef HASH_PACK_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [63:0] exp_word(input logic [31:0] lo, input logic [31:0] hi);
    return {exp_beat(hi), exp_beat(lo)};
  endfunction

  // Write capture and mask invariant
  always @(negedge clk) begin
    if (mon_en) begin
      check("wmask", 64'(bram_wmask), bram_wen ? 64'hFF : 64'h0);
      if (bram_wen) begin
        q_addr.push_back(bram_waddr);
        q_data.push_back(bram_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [CNT_W-1:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    tick();
    start = 1'b0;
  endtask

  // Offer one beat and hold it until consumed (bounded)
  task automatic send_beat(input logic [31:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) check("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [63:0] d);
    if (idx < q_addr.size()) begin
      check({tag, "_addr"}, 64'(q_addr[idx]), 64'(a));
      check({tag, "_data"}, q_data[idx], d);
    end else begin
      check({tag, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    int wb;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wen", 64'(bram_wen), 64'd0);
    check("rst_waddr", 64'(bram_waddr), 64'd0);
    check("rst_wdata", bram_wdata, 64'd0);
    check("rst_hash_ready", 64'(HASH_ready), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Back-to-back fill, count 2
    wb = q_addr.size();
    do_start(32'h100, 16'd2);
    check("t1_in_ready_s1", 64'(in_ready), 64'd1);
    send_beat(32'hA0); send_beat(32'hA1); send_beat(32'hA2); send_beat(32'hA3);
    in_data = 32'hEE;  // keep offering: must not be consumed
    check("t1_wen_h1", 64'(bram_wen), 64'd1);
    check("t1_ready_h1", 64'(HASH_ready), 64'd0);
    check("t1_in_ready_drain", 64'(in_ready), 64'd0);
    tick();
    check("t1_ready_h2", 64'(HASH_ready), 64'd1);
    check("t1_wen_h2", 64'(bram_wen), 64'd0);
    tick(); tick(); tick();
    check("t1_in_ready_done", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    check("t1_nwrites", 64'(q_addr.size() - wb), 64'd2);
    check_write("t1_w0", wb, 32'h100, exp_word(32'hA0, 32'hA1));
    check_write("t1_w1", wb + 1, 32'h108, exp_word(32'hA2, 32'hA3));

    // Same fill with in_valid toggling
    wb = q_addr.size();
    do_start(32'h100, 16'd2);
    check("t2_ready_clr", 64'(HASH_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      send_beat(32'hA0 + 32'(k));
      in_valid = 1'b0;
      if (k < 3) check("t2_in_ready_gap", 64'(in_ready), 64'd1);
      tick();
    end
    tick(); tick();
    check("t2_ready", 64'(HASH_ready), 64'd1);
    check("t2_nwrites", 64'(q_addr.size() - wb), 64'd2);
    check_write("t2_w0", wb, 32'h100, exp_word(32'hA0, 32'hA1));
    check_write("t2_w1", wb + 1, 32'h108, exp_word(32'hA2, 32'hA3));

    // Zero-word fill
    wb = q_addr.size();
    do_start(32'h180, 16'd0);
    check("t3_ready_s1", 64'(HASH_ready), 64'd1);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    tick(); tick(); tick();
    check("t3_nwrites", 64'(q_addr.size() - wb), 64'd0);

    // Address wrap
    wb = q_addr.size();
    do_start(32'hFFFF_FFF8, 16'd2);
    send_beat(32'h1); send_beat(32'h2); send_beat(32'h3); send_beat(32'h4);
    in_valid = 1'b0;
    tick(); tick();
    check("t4_nwrites", 64'(q_addr.size() - wb), 64'd2);
    check_write("t4_w0", wb, 32'hFFFF_FFF8, exp_word(32'h1, 32'h2));
    check_write("t4_w1", wb + 1, 32'h0, exp_word(32'h3, 32'h4));

    // Start during fill is ignored
    wb = q_addr.size();
    do_start(32'h300, 16'd2);
    send_beat(32'hB0);
    in_valid = 1'b0;
    do_start(32'h200, 16'd1);
    check("t5_in_ready_mid", 64'(in_ready), 64'd1);
    check("t5_ready_mid", 64'(HASH_ready), 64'd0);
    send_beat(32'hB1); send_beat(32'hB2); send_beat(32'hB3);
    in_valid = 1'b0;
    tick(); tick();
    check("t5_ready", 64'(HASH_ready), 64'd1);
    check("t5_nwrites", 64'(q_addr.size() - wb), 64'd2);
    check_write("t5_w0", wb, 32'h300, exp_word(32'hB0, 32'hB1));
    check_write("t5_w1", wb + 1, 32'h308, exp_word(32'hB2, 32'hB3));

    // Reset between lo and hi beats of word 1
    wb = q_addr.size();
    do_start(32'h400, 16'd3);
    send_beat(32'hC0); send_beat(32'hC1); send_beat(32'hC2);
    in_data = 32'hC3;
    rst_n = 1'b0;
    tick();
    check("t6_in_ready", 64'(in_ready), 64'd0);
    check("t6_wen", 64'(bram_wen), 64'd0);
    check("t6_waddr", 64'(bram_waddr), 64'd0);
    check("t6_wdata", bram_wdata, 64'd0);
    check("t6_hash_ready", 64'(HASH_ready), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_idle_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("t6_nwrites", 64'(q_addr.size() - wb), 64'd1);
    check_write("t6_w0", wb, 32'h400, exp_word(32'hC0, 32'hC1));

    // Beat ordering / optional byte swap
    wb = q_addr.size();
    do_start(32'h500, 16'd1);
    send_beat(32'h1122_3344); send_beat(32'h5566_7788);
    in_valid = 1'b0;
    tick(); tick();
    check("t7_nwrites", 64'(q_addr.size() - wb), 64'd1);
`ifdef HASH_PACK_BSWAP_EN
    check_write("t7_w0", wb, 32'h500, 64'h8877_6655_4433_2211);
`else
    check_write("t7_w0", wb, 32'h500, 64'h5566_7788_1122_3344);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
